alu_req_arbiter: RTL and testbench

Shares the single 8-bit ALU between two independent requesters. Each requester submits an operation (A, B, Sel, CarryIn) over a valid/ready handshake. The block selects one requester round-robin and drives the ALU operand and select inputs. It waits out the ALU's fixed input-synchroniser latency, captures Y, and returns it tagged with the requester ID over a valid/ready response channel. Only one operation is in flight at a time; the block sits between the bus-side requesters and the ALU instance.

---
 rtl/alu_req_arbiter_pkg.sv | 25 ++
 rtl/alu_req_arbiter_if.sv | 49 ++++
 rtl/alu_req_arbiter_rr.sv | 33 +++
 rtl/alu_req_arbiter.sv | 104 ++++++++++
 tb/tb_alu_req_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the ALU request arbiter.
// Provides the FSM states, the ALU Sel opcodes and the default ALU latency.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_XOR   = 5'b00010;
  localparam logic [4:0] OP_NOTA  = 5'b00011;
  localparam logic [4:0] OP_PASSA = 5'b00100;
  localparam logic [4:0] OP_ADDC  = 5'b00101;
  localparam logic [4:0] OP_ADD   = 5'b00110;
  localparam logic [4:0] OP_PASSB = 5'b00111;
  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b10000;
  localparam logic [4:0] OP_ZERO  = 5'b11000;

  localparam int ALU_LAT_DEF = 3;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and
// the arbiter. master = requester/consumer side, slave = arbiter side.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 5
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_sel;
  logic              req0_cin;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_sel;
  logic              req1_cin;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req0_sel, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    output req1_sel, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req0_sel, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    input  req1_sel, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_req_arbiter_rr.sv
// Two-way round-robin grant. Ports: clk, rst, valid0/1 in,
// accept in (grant taken), grant out (winning ID), any out (a valid exists).
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant,
  output logic any
);

  logic rr_last;

  always_comb begin
    grant = 1'b0;
    any   = valid0 | valid1;
    unique case ({valid1, valid0})
      2'b11:   grant = ~rr_last;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  // rr_last=1 out of reset so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= 1'b1;
    else if (accept)
      rr_last <= grant;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters, one operation in flight.
// Ports: clk, rst, bus (req0/req1/rsp handshakes), alu_* drive, alu_y, busy.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 5,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  alu_req_arbiter_if.slave  bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_y,
  output logic              busy
);

  localparam int CW = $clog2(ALU_LAT + 1);

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic              grant;
  logic              any;
  logic              accept;
  logic              idle;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .accept (accept),
    .grant  (grant),
    .any    (any)
  );

  assign idle   = (state == IDLE);
  assign accept = idle && any && !rst;
  assign busy   = !idle;

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_id     = rsp_id;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = WAIT;
      WAIT: if (cnt == '0) state_n = RESP;
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        alu_a   <= grant ? bus.req1_a   : bus.req0_a;
        alu_b   <= grant ? bus.req1_b   : bus.req0_b;
        alu_sel <= grant ? bus.req1_sel : bus.req0_sel;
        alu_cin <= grant ? bus.req1_cin : bus.req0_cin;
        rsp_id  <= grant;
        cnt     <= CW'(ALU_LAT);
      end
      // Y is only trusted once the synchroniser has fully flushed
      if (state == WAIT) begin
        if (cnt == '0) begin
          rsp_data  <= alu_y;
          rsp_valid <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (state == RESP && bus.rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int SW  = 5;
  localparam int LAT = ALU_LAT_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_sel;
  logic          alu_cin;
  logic [DW-1:0] alu_y;
  logic          busy;

  int errors = 0;
  int checks = 0;

  alu_req_arbiter_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

  alu_req_arbiter #(
    .DATA_W  (DW),
    .SEL_W   (SW),
    .ALU_LAT (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_cin (alu_cin),
    .alu_y   (alu_y),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(
    logic [7:0] a, logic [7:0] b, logic [4:0] s, logic c);
    case (s)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_NOTA:  return ~a;
      OP_PASSA: return a;
      OP_ADDC:  return a + b + 8'(c);
      OP_ADD:   return a + b;
      OP_PASSB: return b;
      OP_SHL:   return a << 1;
      OP_SHR:   return a >> 1;
      default:  return 8'h00;
    endcase
  endfunction

  // ALU with a 3-deep input synchroniser
  logic [7:0] p0 = '0;
  logic [7:0] p1 = '0;
  logic [7:0] p2 = '0;
  always @(posedge clk) begin
    p0 <= alu_ref(alu_a, alu_b, alu_sel, alu_cin);
    p1 <= p0;
    p2 <= p1;
  end
  assign alu_y = p2;

  // Transaction-level model: an accepted op produces its result
  // LAT+1 edges later and waits there for the consumer.
  int         m_left = 0;
  bit         m_rv   = 1'b0;
  logic [7:0] m_rd   = '0;
  logic [7:0] m_pd   = '0;
  bit         m_rid  = 1'b0;
  bit         m_pid  = 1'b0;
  bit         m_last = 1'b1;

  function automatic int m_grant();
    if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_idle();
    return m_left == 0 && !m_rv;
  endfunction

  function automatic bit exp_rdy(int n);
    return !rst && m_idle() && m_grant() == n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_rv = 0; m_rd = '0; m_rid = 0; m_last = 1;
    end else if (m_rv) begin
      if (bus.rsp_ready) m_rv = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_rv = 1; m_rd = m_pd; m_rid = m_pid;
      end
    end else if (m_grant() >= 0) begin
      m_left = LAT + 1;
      m_pid  = (m_grant() == 1);
      m_last = m_pid;
      m_pd   = m_pid ?
        alu_ref(bus.req1_a, bus.req1_b, bus.req1_sel, bus.req1_cin) :
        alu_ref(bus.req0_a, bus.req0_b, bus.req0_sel, bus.req0_cin);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic set_req0(logic [7:0] a, logic [7:0] b,
                          logic [4:0] s, logic c);
    bus.req0_valid = 1'b1;
    bus.req0_a = a; bus.req0_b = b;
    bus.req0_sel = s; bus.req0_cin = c;
  endtask

  task automatic set_req1(logic [7:0] a, logic [7:0] b,
                          logic [4:0] s, logic c);
    bus.req1_valid = 1'b1;
    bus.req1_a = a; bus.req1_b = b;
    bus.req1_sel = s; bus.req1_cin = c;
  endtask

  // Returns on the negedge after the handshake edge.
  task automatic wait_accept(output int id, output bit ok);
    id = -1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        id = bus.req1_ready ? 1 : 0;
        ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts edges from the handshake edge until rsp_valid is seen.
  task automatic wait_rsp(output int edges, output bit ok);
    edges = -1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.rsp_valid) begin
        edges = i;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req0(8'h11, 8'h22, OP_ADD, 1'b1);
    set_req1(8'h33, 8'h44, OP_OR, 1'b1);
    cyc(2);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready: got %b want 00",
               {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_valid_busy: got %b want 00",
               {bus.rsp_valid, busy});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== '0) begin
      errors++;
      $display("FAIL rst_alu: got %h %h %h %b want zero",
               alu_a, alu_b, alu_sel, alu_cin);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_id} !== 9'h0) begin
      errors++;
      $display("FAIL rst_rsp: got %h/%b want 00/0",
               bus.rsp_data, bus.rsp_id);
    end
    idle_reqs();
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_single_add();
    int id, e;
    bit ok;
    set_req0(8'h3C, 8'h05, OP_ADD, 1'b0);
    wait_accept(id, ok);
    checks++;
    if (!ok || id != 0) begin
      errors++;
      $display("FAIL add_grant: got %0d want 0", id);
    end
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL add_wait: ready,busy got %b want 01",
               {bus.req0_ready, busy});
    end
    wait_rsp(e, ok);
    checks++;
    if (!ok || e != LAT + 1) begin
      errors++;
      $display("FAIL add_latency: got %0d want %0d", e, LAT + 1);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_id} !== {8'h41, 1'b0}) begin
      errors++;
      $display("FAIL add_data: got %h/%b want 41/0",
               bus.rsp_data, bus.rsp_id);
    end
    cyc(1);
    #1;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL add_done: valid,busy got %b want 00",
               {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_addc_wrap();
    int id, e;
    bit ok;
    set_req1(8'hFF, 8'h01, OP_ADDC, 1'b1);
    wait_accept(id, ok);
    checks++;
    if (!ok || id != 1) begin
      errors++;
      $display("FAIL addc_grant: got %0d want 1", id);
    end
    bus.req1_valid = 1'b0;
    wait_rsp(e, ok);
    checks++;
    if (!ok || e != LAT + 1) begin
      errors++;
      $display("FAIL addc_latency: got %0d want %0d", e, LAT + 1);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_id} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL addc_data: got %h/%b want 01/1",
               bus.rsp_data, bus.rsp_id);
    end
    cyc(1);
  endtask

  task automatic test_fairness();
    int id, e;
    bit ok;
    logic [7:0] want;
    set_req0(8'hAA, 8'hFF, OP_XOR, 1'b0);
    set_req1(8'h81, 8'h00, OP_SHL, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_accept(id, ok);
      checks++;
      if (!ok || id != (k % 2)) begin
        errors++;
        $display("FAIL fair_grant%0d: got %0d want %0d", k, id, k % 2);
      end
      wait_rsp(e, ok);
      want = (k % 2 == 1) ? 8'h02 : 8'h55;
      checks++;
      if (!ok || bus.rsp_data !== want ||
          bus.rsp_id !== 1'(k % 2)) begin
        errors++;
        $display("FAIL fair_rsp%0d: got %h/%b want %h/%0d",
                 k, bus.rsp_data, bus.rsp_id, want, k % 2);
      end
    end
    idle_reqs();
    cyc(2);
  endtask

  task automatic test_backpressure();
    int id, e;
    bit ok;
    bus.rsp_ready = 1'b0;
    set_req0(8'h12, 8'h34, OP_ADD, 1'b0);
    wait_accept(id, ok);
    bus.req0_valid = 1'b0;
    set_req1(8'h01, 8'h02, OP_OR, 1'b0);
    wait_rsp(e, ok);
    checks++;
    if (!ok || id != 0 || bus.rsp_data !== 8'h46) begin
      errors++;
      $display("FAIL bp_first: got id %0d data %h want 0/46",
               id, bus.rsp_data);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy,
           bus.req0_ready, bus.req1_ready} !==
          {1'b1, 8'h46, 1'b0, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v%b d%h id%b busy%b rdy%b%b", k,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy,
                 bus.req0_ready, bus.req1_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    cyc(1);
    #1;
    checks++;
    if ({bus.rsp_valid, busy, bus.req1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_release: valid,busy,rdy1 got %b want 001",
               {bus.rsp_valid, busy, bus.req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    idle_reqs();
    wait_rsp(e, ok);
    checks++;
    if (!ok || {bus.rsp_data, bus.rsp_id} !== {8'h03, 1'b1}) begin
      errors++;
      $display("FAIL bp_second: got %h/%b want 03/1",
               bus.rsp_data, bus.rsp_id);
    end
    cyc(1);
  endtask

  task automatic test_reset_mid_wait();
    int id, e;
    bit ok, seen;
    set_req0(8'h11, 8'h22, OP_ADD, 1'b0);
    wait_accept(id, ok);
    idle_reqs();
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_state: valid,busy got %b want 00",
               {bus.rsp_valid, busy});
    end
    seen = 1'b0;
    repeat (10) begin
      cyc(1);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard: rsp_valid rose got 1 want 0");
    end
    set_req0(8'h5A, 8'hA5, OP_ZERO, 1'b1);
    wait_accept(id, ok);
    idle_reqs();
    wait_rsp(e, ok);
    checks++;
    if (!ok || id != 0 || e != LAT + 1 ||
        {bus.rsp_data, bus.rsp_id} !== 9'h0) begin
      errors++;
      $display("FAIL midrst_next: got id%0d lat%0d %h want 0/%0d/00",
               id, e, bus.rsp_data, LAT + 1);
    end
    cyc(1);
  endtask

  task automatic test_operand_change();
    int id, e;
    bit ok;
    set_req0(8'h77, 8'h00, OP_PASSA, 1'b0);
    wait_accept(id, ok);
    bus.req0_valid = 1'b0;
    set_req1(8'h10, 8'h00, OP_SHR, 1'b0);
    cyc(2);
    bus.req1_a = 8'h20;
    wait_rsp(e, ok);
    checks++;
    if (!ok || id != 0 || {bus.rsp_data, bus.rsp_id} !== {8'h77, 1'b0}) begin
      errors++;
      $display("FAIL opchg_first: got %0d %h want 0 77", id, bus.rsp_data);
    end
    wait_accept(id, ok);
    checks++;
    if (!ok || id != 1) begin
      errors++;
      $display("FAIL opchg_grant: got %0d want 1", id);
    end
    idle_reqs();
    wait_rsp(e, ok);
    checks++;
    if (!ok || {bus.rsp_data, bus.rsp_id} !== {8'h10, 1'b1}) begin
      errors++;
      $display("FAIL opchg_data: got %h/%b want 10/1",
               bus.rsp_data, bus.rsp_id);
    end
    cyc(1);
  endtask

  task automatic test_random();
    logic [4:0] ops [11];
    ops = '{OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_PASSA, OP_ADDC,
            OP_ADD, OP_PASSB, OP_SHL, OP_SHR, OP_ZERO};
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req0_a   = 8'($urandom);
      bus.req0_b   = 8'($urandom);
      bus.req0_sel = ops[$urandom_range(0, 10)];
      bus.req0_cin = 1'($urandom_range(0, 1));
      bus.req1_a   = 8'($urandom);
      bus.req1_b   = 8'($urandom);
      bus.req1_sel = ops[$urandom_range(0, 10)];
      bus.req1_cin = 1'($urandom_range(0, 1));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !==
          {exp_rdy(0), exp_rdy(1)}) begin
        errors++;
        $display("FAIL rnd_ready@%0d: got %b%b want %b%b", c,
                 bus.req0_ready, bus.req1_ready, exp_rdy(0), exp_rdy(1));
      end
      checks++;
      if ({bus.rsp_valid, busy} !== {m_rv, !m_idle()}) begin
        errors++;
        $display("FAIL rnd_state@%0d: valid,busy got %b%b want %b%b", c,
                 bus.rsp_valid, busy, m_rv, !m_idle());
      end
      if (m_rv) begin
        checks++;
        if ({bus.rsp_data, bus.rsp_id} !== {m_rd, m_rid}) begin
          errors++;
          $display("FAIL rnd_rsp@%0d: got %h/%b want %h/%b", c,
                   bus.rsp_data, bus.rsp_id, m_rd, m_rid);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_reqs();
    bus.rsp_ready = 1'b1;
    cyc(10);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_addc_wrap();
    test_fairness();
    test_backpressure();
    test_reset_mid_wait();
    test_operand_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
